corr_readout: RTL
=================

CORR_READOUT -- requirements
Module: corr_readout

Interface
REQ-001 Parameter ADDR_W, default 7: bin address width; the dump covers 2**ADDR_W bins.
REQ-002 Parameter RD_LAT, default 3: cycles from an rAddr change to valid rData.
REQ-003 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port start, input, 1: one-cycle request to dump all bins.
REQ-006 Port auto_clr, input, 1: sampled with start; 1 means clear the bins after the dump.
REQ-007 Port busy, output, 1: high from accepted start until done.
REQ-008 Port done, output, 1: one-cycle pulse when the dump (and any clear) completes.
REQ-009 Port read, output, 1: read enable to the MAC bank.
REQ-010 Port rAddr, output, ADDR_W: bin read address.
REQ-011 Port rData, input, 32: bin data from the MAC bank.
REQ-012 Port clr, output, 1: one-cycle clear request to the MAC bank.
REQ-013 Port tx_data, output, 8: byte stream to the host link.
REQ-014 Port tx_valid, output, 1: tx_data holds a valid byte.
REQ-015 Port tx_ready, input, 1: sink accepts the byte.

Function
REQ-016 States SHALL be IDLE, HDR, ADDR, SEND, CLR, CLRWAIT, DONE.
REQ-017 IDLE: start=1 SHALL latch auto_clr, set busy, set rAddr=0 and go to HDR (macro on) or ADDR (macro off); start in any other state SHALL be ignored.
REQ-018 ADDR: read=1, rAddr held stable; rData SHALL be captured after RD_LAT cycles (RD_LAT+1 for bin 0, allowing for read rising), then go to SEND.
REQ-019 SEND: the captured word SHALL be emitted as 4 bytes, MSB first; a byte transfers only on a cycle with tx_valid=1 and tx_ready=1.
REQ-020 While tx_valid=1 and tx_ready=0, tx_data SHALL hold stable; tx_valid SHALL not drop before transfer.
REQ-021 After byte 3: if rAddr != 2**ADDR_W-1, increment rAddr and go to ADDR; otherwise deassert read and go to CLR if auto_clr was latched, else DONE.
REQ-022 read SHALL stay high continuously from the first ADDR entry until the last word is captured, including SEND.
REQ-023 CLR: clr=1 for exactly one cycle with read=0; then CLRWAIT for 2**ADDR_W+2 cycles.
REQ-024 DONE: done=1 for one cycle, busy=0, return to IDLE.
REQ-025 rAddr SHALL never wrap during a dump; exactly 2**ADDR_W words (4*2**ADDR_W bytes plus any header) SHALL be emitted per start.
REQ-026 With tx_ready held at 1, each word SHALL take RD_LAT+4 cycles (RD_LAT+5 for bin 0).

Reset
REQ-027 When rst_n=0, state SHALL be IDLE and busy, done, read, clr and tx_valid SHALL be 0; rAddr and tx_data SHALL be 0.
REQ-028 Reset mid-dump SHALL abort with no clr issued; the next start SHALL restart at bin 0.

Configuration
REQ-029 Macro READOUT_HEADER_EN defined: the HDR state SHALL send 0xA5 then 0x5A under the REQ-019/020 handshake before bin 0; read SHALL stay 0 during HDR.
REQ-030 Macro READOUT_HEADER_EN undefined: the HDR state and its logic SHALL be absent; the first byte SHALL be bin 0's MSB.

Verification
REQ-031 Bins preloaded with bin value = 0x01000000+i; start with tx_ready=1 -> 512 bytes in order, starting 01 00 00 00, 01 00 00 01, and ending 01 00 00 7F.
REQ-032 tx_ready toggled pseudo-randomly -> identical byte sequence; tx_data stable in every stalled cycle; read never drops mid-dump.
REQ-033 start with auto_clr=1 -> a single clr pulse after the last byte, with read=0 that cycle; done 130 cycles later; a second dump returns all zeros.
REQ-034 rst_n asserted during SEND of bin 40 -> all outputs 0 immediately, no clr; the next start emits bin 0 first.
REQ-035 READOUT_HEADER_EN defined -> stream begins A5 5A and totals 514 bytes; undefined -> 512 bytes; start pulsed while busy -> no effect.

Source files
------------

// File: rtl/corr_readout.sv
// ---------------------------------------------------------------------------
// corr_readout
// Dumps every bin of a correlator MAC bank to a byte-wide host link and can
// clear the bank once the dump has completed.
//
// Parameters
//   ADDR_W : bin address width; one dump covers 2**ADDR_W bins
//   RD_LAT : cycles from an rAddr change until rData is valid
//
// Ports
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   start, auto_clr     : one-cycle dump request; auto_clr is sampled with it
//   busy, done          : dump in progress / one-cycle completion pulse
//   read, rAddr, rData  : MAC bank read port (rData is 32-bit bin data)
//   clr                 : one-cycle clear request to the MAC bank
//   tx_data, tx_valid,  : byte stream to the host, valid/ready handshake,
//   tx_ready              32-bit words sent MSB first
//
// Build option
//   READOUT_HEADER_EN   : when defined, each dump is preceded by 0xA5 0x5A
// ---------------------------------------------------------------------------
module corr_readout #(
    parameter int ADDR_W = 7,
    parameter int RD_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              auto_clr,
    output logic              busy,
    output logic              done,
    output logic              read,
    output logic [ADDR_W-1:0] rAddr,
    input  logic [31:0]       rData,
    output logic              clr,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam int WAIT_CYC = (1 << ADDR_W) + 2;
    localparam int CNT_MAX  = (WAIT_CYC > RD_LAT + 1) ? WAIT_CYC : RD_LAT + 1;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    // Bin 0 waits one extra cycle because read only rises on entry to ADDR.
    localparam logic [CNT_W-1:0] LAT_LAST      = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] LAT_LAST_BIN0 = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] WAIT_LAST     = CNT_W'(WAIT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
`ifdef READOUT_HEADER_EN
        ST_HDR     = 3'd1,
`endif
        ST_ADDR    = 3'd2,
        ST_SEND    = 3'd3,
        ST_CLR     = 3'd4,
        ST_CLRWAIT = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t            state_r, state_s;
    logic              auto_clr_r, auto_clr_s;
    logic [23:0]       word_r, word_s;       // MSB byte goes straight to tx_data
    logic [1:0]        byte_cnt_r, byte_cnt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              busy_s, done_s, read_s, clr_s, tx_valid_s;
    logic [ADDR_W-1:0] raddr_s;
    logic [7:0]        tx_data_s;
`ifdef READOUT_HEADER_EN
    logic              hdr_sel_r, hdr_sel_s;
`endif

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            auto_clr_r <= 1'b0;
            word_r     <= 24'h0;
            byte_cnt_r <= 2'd0;
            cnt_r      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            read       <= 1'b0;
            clr        <= 1'b0;
            rAddr      <= '0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
`ifdef READOUT_HEADER_EN
            hdr_sel_r  <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            auto_clr_r <= auto_clr_s;
            word_r     <= word_s;
            byte_cnt_r <= byte_cnt_s;
            cnt_r      <= cnt_s;
            busy       <= busy_s;
            done       <= done_s;
            read       <= read_s;
            clr        <= clr_s;
            rAddr      <= raddr_s;
            tx_data    <= tx_data_s;
            tx_valid   <= tx_valid_s;
`ifdef READOUT_HEADER_EN
            hdr_sel_r  <= hdr_sel_s;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        auto_clr_s = auto_clr_r;
        word_s     = word_r;
        byte_cnt_s = byte_cnt_r;
        cnt_s      = cnt_r;
        busy_s     = busy;
        done_s     = 1'b0;
        read_s     = read;
        clr_s      = 1'b0;
        raddr_s    = rAddr;
        tx_data_s  = tx_data;
        tx_valid_s = tx_valid;
`ifdef READOUT_HEADER_EN
        hdr_sel_s  = hdr_sel_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    auto_clr_s = auto_clr;
                    busy_s     = 1'b1;
                    raddr_s    = '0;
                    cnt_s      = '0;
`ifdef READOUT_HEADER_EN
                    state_s    = ST_HDR;
                    tx_valid_s = 1'b1;
                    tx_data_s  = 8'hA5;
                    hdr_sel_s  = 1'b0;
`else
                    state_s    = ST_ADDR;
                    read_s     = 1'b1;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
`ifdef READOUT_HEADER_EN
            ST_HDR: begin
                if (tx_valid && tx_ready) begin
                    if (!hdr_sel_r) begin
                        hdr_sel_s = 1'b1;
                        tx_data_s = 8'h5A;
                    end else begin
                        tx_valid_s = 1'b0;
                        read_s     = 1'b1;
                        cnt_s      = '0;
                        state_s    = ST_ADDR;
                    end
                end else begin
                    state_s = ST_HDR;
                end
            end
`endif
            ST_ADDR: begin
                if (cnt_r == ((rAddr == '0) ? LAT_LAST_BIN0 : LAT_LAST)) begin
                    word_s     = rData[23:0];
                    tx_data_s  = rData[31:24];
                    tx_valid_s = 1'b1;
                    byte_cnt_s = 2'd0;
                    state_s    = ST_SEND;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            ST_SEND: begin
                if (tx_valid && tx_ready) begin
                    if (byte_cnt_r == 2'd3) begin
                        tx_valid_s = 1'b0;
                        if (rAddr != LAST_ADDR) begin
                            raddr_s = rAddr + ADDR_W'(1'b1);
                            cnt_s   = '0;
                            state_s = ST_ADDR;
                        end else begin
                            read_s = 1'b0;
                            if (auto_clr_r) begin
                                clr_s   = 1'b1;
                                state_s = ST_CLR;
                            end else begin
                                done_s  = 1'b1;
                                busy_s  = 1'b0;
                                state_s = ST_DONE;
                            end
                        end
                    end else begin
                        byte_cnt_s = byte_cnt_r + 2'd1;
                        case (byte_cnt_r)
                            2'd0:    tx_data_s = word_r[23:16];
                            2'd1:    tx_data_s = word_r[15:8];
                            default: tx_data_s = word_r[7:0];
                        endcase
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_CLR: begin
                cnt_s   = '0;
                state_s = ST_CLRWAIT;
            end
            ST_CLRWAIT: begin
                if (cnt_r == WAIT_LAST) begin
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s    = ST_IDLE;
                busy_s     = 1'b0;
                read_s     = 1'b0;
                tx_valid_s = 1'b0;
            end
        endcase
    end

endmodule
